// File: rtl/pos_cell_reader_if.sv
// Memory read port and output stream of the cell position reader.
// master = reader side, slave = memory/consumer side.
interface pos_cell_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output mem_addr, mem_rden, mem_wren,
    input  mem_q,
    output out_data, out_index, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  mem_addr, mem_rden, mem_wren,
    output mem_q,
    input  out_data, out_index, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/pos_cell_reader.sv
// Streams one cell's particle positions (count at address 0, words at 1..count) through a credit-limited FIFO.
// Optional count range check: define POS_READER_COUNT_CHECK_EN.
//
// state    | meaning
// IDLE     | waiting for start
// CNT_REQ  | read of count word (address 0) issued
// CNT_WAIT | waiting for count word; latch it
// STREAM   | issuing particle reads while credit allows
// DRAIN    | all reads issued, emptying pipeline and FIFO
// DONE     | one-cycle done pulse
module pos_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic count_err,
  pos_cell_reader_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {IDLE, CNT_REQ, CNT_WAIT, STREAM, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [ADDR_WIDTH-1:0] cnt_in;
  logic                  cnt_seen;
  logic                  cnt_ret;
  logic [1:0]            rd_vld;
  logic [ADDR_WIDTH-1:0] rd_idx [2];

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_idx  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      head_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [CNT_W:0]        occ;
  logic                  credit_ok;
  logic                  issue;
  logic                  push;
  logic                  pop;

  assign cnt_ret   = rd_vld[1] && (state == CNT_WAIT);
  assign push      = rd_vld[1] && (state == STREAM || state == DRAIN);
  assign pop       = (fifo_cnt != '0) && bus.out_ready;
  // Conservative credit: pops in this cycle are not counted, inflight reads are.
  assign occ       = {1'b0, fifo_cnt} + (CNT_W+1)'(rd_vld[0]) + (CNT_W+1)'(rd_vld[1]);
  assign credit_ok = occ < (CNT_W+1)'(FIFO_DEPTH);

`ifdef POS_READER_COUNT_CHECK_EN
  logic count_err_q;
  logic cnt_over;
  assign cnt_over = bus.mem_q[ADDR_WIDTH-1:0] > MAX_COUNT;
  assign cnt_in   = cnt_over ? MAX_COUNT : bus.mem_q[ADDR_WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      count_err_q <= 1'b0;
    else if (state == IDLE && start) count_err_q <= 1'b0;
    else if (cnt_ret)                count_err_q <= cnt_over;
  end
  assign count_err = count_err_q;
`else
  assign cnt_in    = bus.mem_q[ADDR_WIDTH-1:0];
  assign count_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = CNT_REQ;
      CNT_REQ:  state_nxt = CNT_WAIT;
      // Nonzero count streams straight away; zero count finishes from the latched value.
      CNT_WAIT: begin
        if (cnt_ret && cnt_in != '0)         state_nxt = STREAM;
        else if (cnt_seen && count == '0)    state_nxt = DONE;
      end
      STREAM:   if (issue && rd_ptr == count) state_nxt = DRAIN;
      DRAIN: begin
        if (rd_vld == 2'b00 && (fifo_cnt == '0 || (fifo_cnt == CNT_W'(1) && pop)))
          state_nxt = DONE;
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    issue        = (state == STREAM) && credit_ok;
    bus.mem_rden = (state == CNT_REQ) || issue;
    bus.mem_wren = 1'b0;
    if (state == CNT_REQ) bus.mem_addr = '0;
    else if (issue)       bus.mem_addr = rd_ptr;
    else                  bus.mem_addr = addr_hold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      rd_ptr    <= '0;
      addr_hold <= '0;
      cnt_seen  <= 1'b0;
      rd_vld    <= 2'b00;
      rd_idx[0] <= '0;
      rd_idx[1] <= '0;
    end else begin
      addr_hold <= bus.mem_addr;
      rd_vld    <= {rd_vld[0], bus.mem_rden};
      rd_idx[0] <= bus.mem_addr;
      rd_idx[1] <= rd_idx[0];
      if (state == IDLE && start) cnt_seen <= 1'b0;
      if (cnt_ret) begin
        count    <= cnt_in;
        rd_ptr   <= ADDR_WIDTH'(1);
        cnt_seen <= 1'b1;
      end else if (issue) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_idx[i]  <= '0;
      end
      fifo_last <= '0;
      wr_ptr    <= '0;
      head_ptr  <= '0;
      fifo_cnt  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= bus.mem_q;
        fifo_idx[wr_ptr]  <= rd_idx[1];
        fifo_last[wr_ptr] <= (rd_idx[1] == count);
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) head_ptr <= head_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign bus.out_valid = (fifo_cnt != '0);
  assign bus.out_data  = fifo_data[head_ptr];
  assign bus.out_index = fifo_idx[head_ptr];
  assign bus.out_last  = fifo_last[head_ptr];

endmodule
